// File: rtl/tt_um_processor.sv
// rtl/tt_um_processor.sv - 4-bit ALU/accumulator tile, one instruction per clock
// Registered result and flags on uo_out; the uio pins are inputs only.
module tt_um_processor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_XOR  = 4'h4, OP_NOT  = 4'h5, OP_SHL  = 4'h6, OP_SHR  = 4'h7,
    OP_INC  = 4'h8, OP_DEC  = 4'h9, OP_MUL  = 4'hA, OP_PASB = 4'hB,
    OP_ACCA = 4'hC, OP_LDA  = 4'hD, OP_RDA  = 4'hE, OP_NOP  = 4'hF
  } opcode_t;

  // The harness calls this pin rst_n, but it is an active-high reset.
  logic rst;
  assign rst = rst_n;

  logic [3:0] a;
  logic [3:0] b;
  opcode_t    op;
  logic [3:0] acc;

  assign a  = ui_in[3:0];
  assign op = opcode_t'(ui_in[7:4]);
  assign b  = uio_in[3:0];

  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:4]};

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic [4:0] add_ab;
  logic [4:0] sub_ab;
  logic [4:0] inc_a;
  logic [4:0] dec_a;
  logic [4:0] acc_sum;
  logic [7:0] prod;

  // Bit 4 of each 5-bit difference is the borrow.
  assign add_ab  = {1'b0, a} + {1'b0, b};
  assign sub_ab  = {1'b0, a} - {1'b0, b};
  assign inc_a   = {1'b0, a} + 5'd1;
  assign dec_a   = {1'b0, a} - 5'd1;
  assign acc_sum = {1'b0, acc} + {1'b0, a};
  assign prod    = {4'h0, a} * {4'h0, b};

  logic [3:0] r;
  logic       c;
  logic       v;

  always_comb begin
    r = 4'h0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        r = add_ab[3:0];
        c = add_ab[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      OP_SUB: begin
        r = sub_ab[3:0];
        c = sub_ab[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SHL: begin
        r = {a[2:0], 1'b0};
        c = a[3];
      end
      OP_SHR: begin
        r = {1'b0, a[3:1]};
        c = a[0];
      end
      OP_INC: begin
        r = inc_a[3:0];
        c = inc_a[4];
        v = ~a[3] & r[3];
      end
      OP_DEC: begin
        r = dec_a[3:0];
        c = dec_a[4];
        v = a[3] & ~r[3];
      end
      OP_MUL: begin
        r = prod[3:0];
        c = |prod[7:4];
      end
      OP_PASB: r = b;
      OP_ACCA: begin
        r = acc_sum[3:0];
        c = acc_sum[4];
        v = (acc[3] == a[3]) && (r[3] != acc[3]);
      end
      OP_LDA:  r = a;
      OP_RDA:  r = acc;
      default: r = 4'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uo_out <= 8'h00;
      acc    <= 4'h0;
    end else if (ena) begin
      if (op != OP_NOP) begin
        uo_out <= {v, r[3], (r == 4'h0), c, r};
      end
      if (op == OP_ACCA) begin
        acc <= acc_sum[3:0];
      end else if (op == OP_LDA) begin
        acc <= a;
      end
    end
  end

endmodule

// File: tb/tb_tt_um_processor.sv
// tb/tb_tt_um_processor.sv - directed-vector bench for tt_um_processor
// Each task drives its scenario and checks uo_out against hand-computed values.
module tb_tt_um_processor;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors;
  int miscompares;

  tt_um_processor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction and wait until just after the edge that consumes it.
  task automatic exec(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    ui_in  = {op, a};
    uio_in = {4'h0, b};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    @(negedge clk);
    vectors++;
    if (uo_out !== 8'h00) begin
      $display("FAIL reset_hold uo_out=%h expected=%h", uo_out, 8'h00);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (uo_out !== 8'h00) begin
      $display("FAIL reset_edge uo_out=%h expected=%h", uo_out, 8'h00);
      miscompares++;
    end
    vectors++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      $display("FAIL uio_const uio_out=%h uio_oe=%h expected=00/00", uio_out, uio_oe);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (uo_out !== 8'h20) begin
      $display("FAIL reset_first_edge uo_out=%h expected=%h", uo_out, 8'h20);
      miscompares++;
    end
  endtask

  task automatic test_add_sweep;
    logic [7:0] exp_v;
    logic [7:0] prev;
    // Sweep B with A=0, then A with B=0: result equals the swept operand.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        exp_v = {4'h0, 4'(i)};
        if (i == 0) exp_v = 8'h20;
        if (i >= 8) exp_v = exp_v | 8'h40;
        prev = uo_out;
        if (pass == 0) begin
          ui_in  = 8'h00;
          uio_in = 8'(i);
        end else begin
          ui_in  = 8'(i);
          uio_in = 8'h00;
        end
        #2;
        vectors++;
        if (uo_out !== prev) begin
          $display("FAIL add_sweep_latency pass=%0d i=%0d uo_out=%h expected=%h", pass, i, uo_out, prev);
          miscompares++;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (uo_out !== exp_v) begin
          $display("FAIL add_sweep pass=%0d i=%0d uo_out=%h expected=%h", pass, i, uo_out, exp_v);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_alu_ops;
    logic [3:0] ops  [20];
    logic [3:0] as   [20];
    logic [3:0] bs   [20];
    logic [7:0] exps [20];
    ops = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
            4'h8, 4'h8, 4'h9, 4'h9, 4'hA, 4'hA, 4'hB, 4'hB, 4'h0, 4'h1};
    as   = '{4'hF, 4'h7, 4'h3, 4'h8, 4'hC, 4'h3, 4'h5, 4'h5, 4'h9, 4'h3,
             4'hF, 4'h7, 4'h0, 4'h8, 4'h5, 4'h3, 4'h7, 4'h7, 4'h8, 4'h5};
    bs   = '{4'h1, 4'h1, 4'h5, 4'h1, 4'hA, 4'h4, 4'h5, 4'h0, 4'h0, 4'h0,
             4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h3, 4'hA, 4'h0, 4'h8, 4'h5};
    exps = '{8'h30, 8'hC8, 8'h5E, 8'h87, 8'h48, 8'h07, 8'h20, 8'h4A, 8'h12, 8'h11,
             8'h30, 8'hC8, 8'h5F, 8'h87, 8'h14, 8'h49, 8'h4A, 8'h20, 8'hB0, 8'h20};
    for (int i = 0; i < 20; i++) begin
      exec(ops[i], as[i], bs[i]);
      vectors++;
      if (uo_out !== exps[i]) begin
        $display("FAIL alu_op idx=%0d op=%h a=%h b=%h uo_out=%h expected=%h",
                 i, ops[i], as[i], bs[i], uo_out, exps[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_accumulator;
    exec(4'hD, 4'h9, 4'h0);
    vectors++;
    if (uo_out !== 8'h49) begin
      $display("FAIL lda uo_out=%h expected=%h", uo_out, 8'h49);
      miscompares++;
    end
    exec(4'hC, 4'h9, 4'h0);
    vectors++;
    if (uo_out !== 8'h92) begin
      $display("FAIL acca uo_out=%h expected=%h", uo_out, 8'h92);
      miscompares++;
    end
    exec(4'hE, 4'h0, 4'h0);
    vectors++;
    if (uo_out !== 8'h02) begin
      $display("FAIL rda uo_out=%h expected=%h", uo_out, 8'h02);
      miscompares++;
    end
    exec(4'hF, 4'h5, 4'h5);
    vectors++;
    if (uo_out !== 8'h02) begin
      $display("FAIL nop_hold uo_out=%h expected=%h", uo_out, 8'h02);
      miscompares++;
    end
    // Non-accumulator opcodes must leave ACC alone.
    exec(4'h0, 4'hF, 4'h3);
    exec(4'hB, 4'h0, 4'h6);
    exec(4'hE, 4'h0, 4'h0);
    vectors++;
    if (uo_out !== 8'h02) begin
      $display("FAIL acc_untouched uo_out=%h expected=%h", uo_out, 8'h02);
      miscompares++;
    end
    // ACC 2 + 7 = 9: sign change from positive operands sets V.
    exec(4'hC, 4'h7, 4'h0);
    vectors++;
    if (uo_out !== 8'hC9) begin
      $display("FAIL acca_ovf uo_out=%h expected=%h", uo_out, 8'hC9);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back;
    exec(4'hD, 4'h2, 4'h0);
    exec(4'h0, 4'h1, 4'h1);
    vectors++;
    if (uo_out !== 8'h02) begin
      $display("FAIL b2b_first uo_out=%h expected=%h", uo_out, 8'h02);
      miscompares++;
    end
    exec(4'hE, 4'h0, 4'h0);
    vectors++;
    if (uo_out !== 8'h02) begin
      $display("FAIL b2b_second uo_out=%h expected=%h", uo_out, 8'h02);
      miscompares++;
    end
  endtask

  task automatic test_enable;
    exec(4'hD, 4'h6, 4'h0);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exec(4'hD, 4'(i + 10), 4'(i));
      vectors++;
      if (uo_out !== 8'h06) begin
        $display("FAIL ena_hold cycle=%0d uo_out=%h expected=%h", i, uo_out, 8'h06);
        miscompares++;
      end
    end
    ena = 1'b1;
    exec(4'hE, 4'h0, 4'h0);
    vectors++;
    if (uo_out !== 8'h06) begin
      $display("FAIL ena_acc_hold uo_out=%h expected=%h", uo_out, 8'h06);
      miscompares++;
    end
  endtask

  task automatic test_async_reset;
    exec(4'h0, 4'h7, 4'h1);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (uo_out !== 8'h00) begin
      $display("FAIL async_reset uo_out=%h expected=%h", uo_out, 8'h00);
      miscompares++;
    end
    #1;
    rst_n = 1'b0;
    exec(4'hE, 4'h0, 4'h0);
    vectors++;
    if (uo_out !== 8'h20) begin
      $display("FAIL reset_clears_acc uo_out=%h expected=%h", uo_out, 8'h20);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    ena         = 1'b1;
    ui_in       = 8'h00;
    uio_in      = 8'h00;
    test_reset();
    test_add_sweep();
    test_alu_ops();
    test_accumulator();
    test_back_to_back();
    test_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
